fetch_unit: RTL and testbench

Instruction-fetch stage of the Mach-V pipeline. It sits directly upstream of the F/D pipeline register. It owns the architectural fetch PC and issues word requests to instruction memory over a one-outstanding request/response handshake. It presents `InstrF`/`PCF` to the F/D register each cycle, handling stalls, execute-stage redirects and variable memory latency, and inserts NOP bubbles when no instruction is ready.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the Mach-V fetch stage.
//   NOP_INSTR_DEF : bubble encoding (addi x0,x0,0)
//   RESET_PC_DEF  : default fetch address after reset
//   fetch_state_t : fetch FSM state encoding
//   pc_inc        : next sequential PC (modulo 2^32)
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // no request outstanding
    ST_WAIT = 2'd1,  // one request outstanding for pc
    ST_HOLD = 2'd2,  // ibuf holds the instruction for pc while stalled
    ST_DROP = 2'd3   // outstanding response is stale and must be drained
  } fetch_state_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the fetch PC, issues word requests to
// instruction memory (one outstanding at a time) and presents the fetched
// instruction to the F/D register, inserting NOP bubbles when nothing is ready.
// Ports:
//   CLK, RESET                  : clock, synchronous active-high reset
//   StallF                      : downstream not accepting, hold instruction
//   PCSrcE, PCTargetE           : execute-stage redirect and its target
//   IMemReq/IMemAddr/IMemReady  : request handshake to instruction memory
//   IMemRValid/IMemRData        : in-order response from instruction memory
//   InstrF/PCF/FetchValidF      : instruction, its PC, and its validity
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic        FetchValidF
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  ibuf, ibuf_n;
  logic [31:0]  target_aligned;
  logic [31:0]  pc_plus4;

  // Low target bits are ignored: all fetches are word aligned.
  assign target_aligned = PCTargetE & 32'hFFFF_FFFC;
  assign pc_plus4       = pc_inc(pc);

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    ibuf_n      = ibuf;
    IMemReq     = 1'b0;
    IMemAddr    = pc;
    InstrF      = NOP_INSTR;
    PCF         = pc;
    FetchValidF = 1'b0;

    unique case (state)
      ST_REQ: begin
        if (PCSrcE) begin
          pc_n = target_aligned;
        end else begin
          // Stall does not block issue: the response will wait in ibuf.
          IMemReq = 1'b1;
          if (IMemReady) state_n = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (!IMemRValid) begin
          if (PCSrcE) begin
            pc_n    = target_aligned;
            state_n = ST_DROP;
          end
        end else if (PCSrcE) begin
          pc_n    = target_aligned;
          state_n = ST_REQ;
        end else if (StallF) begin
          ibuf_n  = IMemRData;
          state_n = ST_HOLD;
        end else begin
          // Pass the response straight through and issue the next fetch in
          // the same cycle to sustain one instruction per cycle.
          InstrF      = IMemRData;
          FetchValidF = 1'b1;
          pc_n        = pc_plus4;
          IMemReq     = 1'b1;
          IMemAddr    = pc_plus4;
          state_n     = IMemReady ? ST_WAIT : ST_REQ;
        end
      end

      ST_HOLD: begin
        if (PCSrcE) begin
          pc_n    = target_aligned;
          state_n = ST_REQ;
        end else begin
          InstrF      = ibuf;
          FetchValidF = 1'b1;
          if (!StallF) begin
            pc_n    = pc_plus4;
            state_n = ST_REQ;
          end
        end
      end

      ST_DROP: begin
        if (PCSrcE) pc_n = target_aligned;
        if (IMemRValid) state_n = ST_REQ;
      end

      default: state_n = ST_REQ;
    endcase

    // Nothing leaves the block while it is being reset.
    if (RESET) begin
      IMemReq     = 1'b0;
      FetchValidF = 1'b0;
      InstrF      = NOP_INSTR;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_REQ;
      pc    <= RESET_PC;
      ibuf  <= 32'd0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ibuf  <= ibuf_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-programmable memory
// responder returning addr ^ 32'hA5A5_0000.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'd0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady = 1'b1;
  logic        IMemRValid = 1'b0;
  logic [31:0] IMemRData = 32'd0;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        FetchValidF;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  int checks = 0;
  int failures = 0;

  fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .StallF(StallF), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemReady(IMemReady), .IMemRValid(IMemRValid), .IMemRData(IMemRData),
    .InstrF(InstrF), .PCF(PCF), .FetchValidF(FetchValidF)
  );

  always #5 CLK = ~CLK;

  // Memory responder: a request accepted in cycle k answers in cycle k+lat.
  int          lat = 1;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic        acc_s = 1'b0, rv_s = 1'b0, rst_s = 1'b1;
  logic [31:0] addr_s = 32'd0;

  always @(negedge CLK) begin
    acc_s  = IMemReq && IMemReady;
    addr_s = IMemAddr;
    rv_s   = IMemRValid;
    rst_s  = RESET;
  end

  always @(posedge CLK) begin
    #1;
    if (rst_s) begin
      pend       = 1'b0;
      IMemRValid = 1'b0;
    end else begin
      if (rv_s) pend = 1'b0;
      if (acc_s) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = addr_s;
      end
      IMemRValid = 1'b0;
      if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          IMemRValid = 1'b1;
          IMemRData  = paddr ^ KEY;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic mid;
    @(negedge CLK);
  endtask

  // Two reset cycles, leaves the bench at the start of cycle 1.
  task automatic do_reset(input int l);
    RESET = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; lat = l;
    next_cycle;
    next_cycle;
    RESET = 1'b0;
  endtask

  initial begin
    // ---------------- reset state, 1-cycle memory throughput
    next_cycle;
    mid;
    chk1("rst_req", IMemReq, 1'b0);
    chk1("rst_vld", FetchValidF, 1'b0);
    chk("rst_instr", InstrF, NOP);
    chk("rst_pcf", PCF, 32'h0);
    next_cycle;
    RESET = 1'b0;
    mid;                                   // c1
    chk1("c1_req", IMemReq, 1'b1);
    chk("c1_addr", IMemAddr, 32'h0);
    chk1("c1_vld", FetchValidF, 1'b0);
    for (int i = 0; i < 3; i++) begin      // c2..c4
      next_cycle;
      mid;
      chk1("tp_vld", FetchValidF, 1'b1);
      chk("tp_pcf", PCF, 32'(4 * i));
      chk("tp_instr", InstrF, 32'(4 * i) ^ KEY);
      chk("tp_addr", IMemAddr, 32'(4 * i + 4));
    end
    // ---------------- 3-cycle latency from the request for 0xC
    lat = 3;
    for (int i = 0; i < 6; i++) begin      // c5..c10
      next_cycle;
      mid;
      chk1("l3_vld", FetchValidF, (i % 3) == 2);
      if ((i % 3) == 2) begin
        chk("l3_pcf", PCF, 32'(12 + 4 * (i / 3)));
        chk("l3_instr", InstrF, 32'(12 + 4 * (i / 3)) ^ KEY);
      end else begin
        chk("l3_nop", InstrF, NOP);
        chk1("l3_noreq", IMemReq, 1'b0);
      end
    end

    // ---------------- stall across the response for 0x8
    do_reset(1);
    next_cycle; next_cycle; next_cycle;    // c4: response for 0x8
    StallF = 1'b1;
    mid;
    chk1("st_resp_vld", FetchValidF, 1'b0);
    for (int i = 0; i < 4; i++) begin      // c5..c8
      next_cycle;
      if (i == 3) StallF = 1'b0;
      else StallF = 1'b1;
      mid;
      chk1("st_hold_vld", FetchValidF, 1'b1);
      chk("st_hold_instr", InstrF, 32'h8 ^ KEY);
      chk("st_hold_pcf", PCF, 32'h8);
    end
    next_cycle;                            // c9
    mid;
    chk("st_rel_addr", IMemAddr, 32'hC);
    chk1("st_rel_req", IMemReq, 1'b1);
    chk("st_rel_pcf", PCF, 32'hC);
    next_cycle;                            // c10
    mid;
    chk("st_next_pcf", PCF, 32'hC);
    chk1("st_next_vld", FetchValidF, 1'b1);

    // ---------------- redirect while 0x10 is outstanding, 2-cycle memory
    do_reset(2);
    for (int i = 0; i < 8; i++) next_cycle; // c9: response for 0xC
    mid;
    chk("rd_pre_pcf", PCF, 32'hC);
    chk("rd_pre_addr", IMemAddr, 32'h10);
    next_cycle;                            // c10: 0x10 outstanding
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    mid;
    chk1("rd_req", IMemReq, 1'b0);
    next_cycle;                            // c11: stale response
    PCSrcE = 1'b0;
    mid;
    chk1("rd_drop_rv", IMemRValid, 1'b1);
    chk1("rd_drop_vld", FetchValidF, 1'b0);
    chk1("rd_drop_req", IMemReq, 1'b0);
    next_cycle;                            // c12
    mid;
    chk1("rd_new_req", IMemReq, 1'b1);
    chk("rd_new_addr", IMemAddr, 32'h100);

    // ---------------- redirect coincident with response and stall
    do_reset(1);
    next_cycle;                            // c2: response for 0x0
    StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h103;
    mid;
    chk1("co_vld", FetchValidF, 1'b0);
    chk("co_instr", InstrF, NOP);
    chk1("co_req", IMemReq, 1'b0);
    next_cycle;                            // c3
    StallF = 1'b0; PCSrcE = 1'b0;
    mid;
    chk("co_addr", IMemAddr, 32'h100);
    chk("co_pcf", PCF, 32'h100);
    next_cycle;                            // c4
    mid;
    chk("co_instr2", InstrF, 32'h100 ^ KEY);
    chk1("co_vld2", FetchValidF, 1'b1);

    // ---------------- redirect to the top word, wraparound, reset in WAIT
    next_cycle;                            // c5: response for 0x104
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    mid;
    chk1("wr_vld", FetchValidF, 1'b0);
    next_cycle;                            // c6
    PCSrcE = 1'b0;
    mid;
    chk("wr_addr_top", IMemAddr, 32'hFFFF_FFFC);
    next_cycle;                            // c7
    mid;
    chk("wr_pcf", PCF, 32'hFFFF_FFFC);
    chk("wr_addr_wrap", IMemAddr, 32'h0);
    next_cycle;                            // c8: reset while in WAIT
    RESET = 1'b1;
    mid;
    chk1("wr_rst_vld", FetchValidF, 1'b0);
    chk1("wr_rst_req", IMemReq, 1'b0);
    next_cycle;                            // c9
    RESET = 1'b0;
    mid;
    chk("wr_after_pcf", PCF, 32'h0);
    chk1("wr_after_vld", FetchValidF, 1'b0);
    chk1("wr_after_req", IMemReq, 1'b1);
    chk("wr_after_addr", IMemAddr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
